mult_ctrl: RTL and testbench

- Sequencing controller for the unsigned shift-add multiplier. It sits directly upstream of the Product register stage.
- Takes a start request and drives the Product stage's load/execute and add-select controls for WIDTH iterations.
- Captures the finished 2*WIDTH-bit product into its own result register and presents it with a rdy/ack handshake.
- The Product stage updates on negedge clk; this block updates on posedge clk, so every control is stable across the Product stage's active edge.

---
 rtl/mult_ctrl.sv | 118 +++++++++++
 tb/tb_mult_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_ctrl.sv
// Sequencing controller for the unsigned shift-add multiplier.
// Drives the Product stage (which updates on negedge) for WIDTH execute
// iterations, captures the 2*WIDTH-bit product and offers it on rdy/ack.
//
// Handshake: rdy is a level that rises on the edge the product is captured
// and stays high, with result frozen, until the consumer asserts ack (or a
// new start) at a posedge while in DONE; rdy falls on that same edge.
// ack outside DONE and start during LOAD/EXEC are ignored, never queued.
module mult_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6   // 2**CNT_W must exceed WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ack,
  input  logic                 lsb,
  input  logic [2*WIDTH-1:0]   product_in,
  output logic                 w_ctrl_Product,
  output logic                 adding_ctrl,
  output logic                 w_ctrl_Multiplicand,
  output logic                 alu_clr,
  output logic                 busy,
  output logic                 rdy,
  output logic [2*WIDTH-1:0]   result,
  output logic [CNT_W-1:0]     iter,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_EXEC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t state;

  // Single FSM process; control outputs are registered alongside the next
  // state so they always equal the Moore decode of the current state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state               <= S_IDLE;
      iter                <= '0;
      result              <= '0;
      rdy                 <= 1'b0;
      busy                <= 1'b0;
      w_ctrl_Product      <= 1'b0;
      w_ctrl_Multiplicand <= 1'b0;
      alu_clr             <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state               <= S_LOAD;
            busy                <= 1'b1;
            w_ctrl_Product      <= 1'b0;
            w_ctrl_Multiplicand <= 1'b1;
            alu_clr             <= 1'b1;
          end
        end
        S_LOAD: begin
          // Product stage loads {0, multiplier} on the negedge inside LOAD.
          state               <= S_EXEC;
          iter                <= '0;
          busy                <= 1'b1;
          w_ctrl_Product      <= 1'b1;
          w_ctrl_Multiplicand <= 1'b0;
          alu_clr             <= 1'b0;
        end
        S_EXEC: begin
          if (iter == LAST_ITER) begin
            // The WIDTH-th negedge update has already happened, so
            // product_in is final on this edge.
            state  <= S_DONE;
            result <= product_in;
            rdy    <= 1'b1;
            iter   <= '0;
            busy   <= 1'b0;
          end else begin
            iter <= iter + 1'b1;
          end
        end
        S_DONE: begin
          // start wins over ack so a new operation can follow immediately.
          if (start) begin
            state               <= S_LOAD;
            rdy                 <= 1'b0;
            busy                <= 1'b1;
            w_ctrl_Product      <= 1'b0;
            w_ctrl_Multiplicand <= 1'b1;
            alu_clr             <= 1'b1;
          end else if (ack) begin
            state          <= S_IDLE;
            rdy            <= 1'b0;
            w_ctrl_Product <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Add-select follows the multiplier bit only while executing.
  always_comb begin
    adding_ctrl = (state == S_EXEC) && lsb;
  end

  // Expose the state encoding for checkers.
  always_comb begin
    state_dbg = state;
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Testbench for mult_ctrl: drives it together with a behavioural Product
// stage / multiplicand register / adder, and checks products, latency,
// add-select activity and the rdy/ack handshake.
module tb_mult_ctrl;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int LAT   = WIDTH + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic              ack;
  logic              lsb;
  logic [63:0]       product_in;
  logic              w_ctrl_Product;
  logic              adding_ctrl;
  logic              w_ctrl_Multiplicand;
  logic              alu_clr;
  logic              busy;
  logic              rdy;
  logic [63:0]       result;
  logic [CNT_W-1:0]  iter;
  logic [1:0]        state_dbg;

  mult_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .start               (start),
    .ack                 (ack),
    .lsb                 (lsb),
    .product_in          (product_in),
    .w_ctrl_Product      (w_ctrl_Product),
    .adding_ctrl         (adding_ctrl),
    .w_ctrl_Multiplicand (w_ctrl_Multiplicand),
    .alu_clr             (alu_clr),
    .busy                (busy),
    .rdy                 (rdy),
    .result              (result),
    .iter                (iter),
    .state_dbg           (state_dbg)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- Product stage, multiplicand and adder ----------------
  logic [31:0] op_a = '0;   // multiplicand operand
  logic [31:0] op_b = '0;   // multiplier operand
  logic [31:0] mcand = '0;
  logic [63:0] prod = '0;
  logic [32:0] sum33;

  always @(negedge clk) begin
    if (w_ctrl_Multiplicand) mcand <= op_a;
    if (!w_ctrl_Product) begin
      prod <= {(alu_clr ? 32'd0 : prod[63:32]), op_b};
    end else begin
      sum33 = {1'b0, prod[63:32]} + (adding_ctrl ? {1'b0, mcand} : 33'd0);
      prod  <= {sum33, prod[31:1]};
    end
  end

  assign lsb        = prod[0];
  assign product_in = prod;

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] last_res = '0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks (entered #1 after a posedge) ----------------
  // Launch one multiply and follow it to rdy. poke_iter >= 0 pulses start
  // once while executing at that iteration; it must be ignored.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int poke_iter,
                        input bit do_ack);
    int  t0;
    int  adds;
    bit  seen;
    bit  stable;
    logic [63:0] want;
    op_a = a;
    op_b = b;
    exp_q.push_back(exp);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("rdy_after_start", rdy, 1'b0);
    chk("load_ctrls", {w_ctrl_Product, w_ctrl_Multiplicand, alu_clr}, 3'b011);
    adds   = 0;
    seen   = 1'b0;
    stable = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (rdy) begin
        seen = 1'b1;
        break;
      end
      if (busy && w_ctrl_Product) adds += int'(adding_ctrl);
      if (result !== last_res) stable = 1'b0;
      if (poke_iter >= 0 && busy && w_ctrl_Product && int'(iter) == poke_iter) start = 1'b1;
    end
    chk("rdy_timeout", seen, 1'b1);
    chk("latency", 64'(cyc - t0), 64'(LAT));
    chk("result_held_while_busy", stable, 1'b1);
    chk("adding_count", 64'(adds), 64'($countones(b)));
    want = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
    chk("result", result, want);
    chk("done_ctrls", {busy, w_ctrl_Product, iter}, {2'b01, {CNT_W{1'b0}}});
    last_res = want;
    if (do_ack) take_result();
  endtask

  task automatic take_result();
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    chk("ack_rdy_low", rdy, 1'b0);
    chk("ack_to_idle", {state_dbg, busy, w_ctrl_Product}, 4'b0000);
    chk("result_after_ack", result, last_res);
  endtask

  // Stay in DONE for n cycles with no ack.
  task automatic hold_done(input int n);
    bit ok_rdy;
    bit ok_res;
    bit ok_add;
    ok_rdy = 1'b1;
    ok_res = 1'b1;
    ok_add = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      if (rdy !== 1'b1 || state_dbg !== 2'd3) ok_rdy = 1'b0;
      if (result !== last_res) ok_res = 1'b0;
      if (adding_ctrl !== 1'b0 || w_ctrl_Product !== 1'b1) ok_add = 1'b0;
    end
    chk("hold_rdy", ok_rdy, 1'b1);
    chk("hold_result", ok_res, 1'b1);
    chk("hold_ctrls", ok_add, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit ok;

    vecs[0] = '{32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'd0,          32'h0001_2345,  64'h0000_0000_0000_0000};
    vecs[3] = '{32'd1,          32'h8000_0000,  64'h0000_0000_8000_0000};
    vecs[4] = '{32'hFFFF_FFFF,  32'd1,          64'h0000_0000_FFFF_FFFF};

    rst   = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #3 rst = 1'b0;      // asynchronous assertion mid-clock
    #1;
    chk("reset_outputs",
        {rdy, busy, w_ctrl_Product, w_ctrl_Multiplicand, alu_clr, adding_ctrl, state_dbg, iter},
        '0);
    chk("reset_result", result, 64'd0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // Idle with start low: nothing moves.
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (state_dbg !== 2'd0 || rdy !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    chk("idle_stays", ok, 1'b1);

    // Table vectors, each acknowledged.
    for (int i = 0; i < 5; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].exp, -1, 1'b1);

    // Handshake: hold rdy with no ack, then ack once.
    run_op(32'd3, 32'd5, 64'd15, -1, 1'b0);
    hold_done(20);
    take_result();

    // start during EXEC at iter 10 is ignored (same result and latency),
    // then back-to-back 7 x 9 issued straight from DONE.
    run_op(32'd3, 32'd5, 64'd15, 10, 1'b0);
    run_op(32'd7, 32'd9, 64'd63, -1, 1'b0);
    take_result();

    // Randomized operands against plain 64-bit multiplication.
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i < 2) ? 32'($urandom_range(0, 255)) : $urandom;
      run_op(ra, rb, {32'd0, ra} * {32'd0, rb}, -1, (i % 2) == 0);
    end
    if (rdy) take_result();

    // Reset mid-operation at iter 17: aborted result is never presented.
    op_a  = 32'h1234;
    op_b  = 32'h5678;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (rdy) break;
      if (iter == 6'd17 && busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_iter17", ok, 1'b1);
    #2 rst = 1'b0;
    #1;
    chk("midop_reset_ctrl", {rdy, busy, w_ctrl_Product, state_dbg, iter}, '0);
    chk("midop_reset_result", result, 64'd0);
    last_res = 64'd0;
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(32'd2, 32'd2, 64'd4, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
